// File: rtl/word_pkg.sv
// Shared constants and state encoding for the text-banner renderer.
// Used by word_renderer, word_row_shifter and word_renderer_if.
package word_pkg;

  localparam int GLYPH_W   = 680;
  localparam int GLYPH_H   = 40;
  localparam int ROW_SEL_W = 6;
  localparam int BITCNT_W  = 10;
  localparam int HCNT_W    = 11;
  localparam int RGB_W     = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

endpackage

// File: rtl/word_renderer_if.sv
// Bus between the VGA timing / glyph ROM side and the banner renderer.
// The slave modport is the renderer; the master modport is whatever drives
// the raster counters and supplies ROM data.
interface word_renderer_if;
  import word_pkg::*;

  logic                  pix_ce;
  logic [HCNT_W-1:0]     hcnt;
  logic [HCNT_W-1:0]     vcnt;
  logic                  vsync_pls;
  logic [ROW_SEL_W-1:0]  choose;
  logic [GLYPH_W-1:0]    word;
  logic                  pixel_on;
  logic [RGB_W-1:0]      rgb;

  modport master (
    output pix_ce, hcnt, vcnt, vsync_pls, word,
    input  choose, pixel_on, rgb
  );

  modport slave (
    input  pix_ce, hcnt, vcnt, vsync_pls, word,
    output choose, pixel_on, rgb
  );

endinterface

// File: rtl/word_row_shifter.sv
// Holds one glyph ROM row and shifts it out MSB-first, one bit per shift
// strobe, with a bit counter that flags the final bit of the row.
module word_row_shifter
  import word_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               shift,
  input  logic [GLYPH_W-1:0] din,
  output logic               msb,
  output logic               last
);

  logic [GLYPH_W-1:0]  shreg;
  logic [BITCNT_W-1:0] bitcnt;

  // Parallel load restarts the row; each shift moves the next bit into the MSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg  <= '0;
      bitcnt <= '0;
    end else if (load) begin
      shreg  <= din;
      bitcnt <= '0;
    end else if (shift) begin
      shreg  <= {shreg[GLYPH_W-2:0], 1'b0};
      bitcnt <= bitcnt + BITCNT_W'(1);
    end
  end

  assign msb  = shreg[GLYPH_W-1];
  assign last = (bitcnt == BITCNT_W'(GLYPH_W - 1));

endmodule

// File: rtl/word_renderer.sv
// Banner renderer: watches the raster counters, selects the glyph ROM row
// two columns ahead of the banner, then serialises the returned row into
// a registered pixel_on/rgb pair aligned one pixel behind hcnt.
// Optional feature macro: BLINK_EN (frame counter blanks the banner for
// 16 of every 32 frames, counted on vsync_pls).
module word_renderer
  import word_pkg::*;
#(
  parameter int               X0     = 200,
  parameter int               Y0     = 100,
  parameter logic [RGB_W-1:0] FG_RGB = 12'hFF0
) (
  input  logic             clk,
  input  logic             rst,
  word_renderer_if.slave   bus
);

  localparam logic [HCNT_W-1:0] TRIG_COL  = HCNT_W'(X0 - 2);
  localparam logic [HCNT_W-1:0] ROW_FIRST = HCNT_W'(Y0);
  localparam logic [HCNT_W-1:0] ROW_END   = HCNT_W'(Y0 + GLYPH_H);

  state_t                state;
  logic [ROW_SEL_W-1:0]  choose_q;
  logic                  pixel_on_q;
  logic [RGB_W-1:0]      rgb_q;

  logic                  row_active;
  logic                  trigger;
  logic [ROW_SEL_W-1:0]  row_idx;
  logic                  sh_load;
  logic                  sh_shift;
  logic                  sh_msb;
  logic                  sh_last;
  logic                  blank;
  logic                  next_bit;

  assign row_active = (bus.vcnt >= ROW_FIRST) && (bus.vcnt < ROW_END);
  assign row_idx    = ROW_SEL_W'(bus.vcnt - ROW_FIRST);
  assign trigger    = row_active && (bus.hcnt == TRIG_COL);

  // A fresh trigger always wins, so a short line restarts the fetch.
  assign sh_load  = bus.pix_ce && !trigger && (state == ST_FETCH);
  assign sh_shift = bus.pix_ce && !trigger && (state == ST_SHIFT);

  word_row_shifter u_shifter (
    .clk   (clk),
    .rst   (rst),
    .load  (sh_load),
    .shift (sh_shift),
    .din   (bus.word),
    .msb   (sh_msb),
    .last  (sh_last)
  );

`ifdef BLINK_EN
  logic [4:0] blink_cnt;

  // Frame counter; its top bit selects the blanked half of the blink cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
    end else if (bus.pix_ce && bus.vsync_pls) begin
      blink_cnt <= blink_cnt + 5'd1;
    end
  end

  assign blank = blink_cnt[4];
`else
  logic unused_vsync;
  assign unused_vsync = bus.vsync_pls;
  assign blank        = 1'b0;
`endif

  assign next_bit = sh_msb & ~blank;

  // Row fetch / serialise sequencer with registered ROM select and pixel outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      choose_q   <= '0;
      pixel_on_q <= 1'b0;
      rgb_q      <= '0;
    end else if (bus.pix_ce) begin
      pixel_on_q <= 1'b0;
      rgb_q      <= '0;
      if (trigger) begin
        choose_q <= row_idx;
        state    <= ST_FETCH;
      end else begin
        case (state)
          ST_IDLE: begin
            state <= ST_IDLE;
          end
          ST_FETCH: begin
            state <= ST_SHIFT;
          end
          ST_SHIFT: begin
            pixel_on_q <= next_bit;
            rgb_q      <= next_bit ? FG_RGB : '0;
            if (sh_last) begin
              state <= ST_IDLE;
            end
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.choose   = choose_q;
  assign bus.pixel_on = pixel_on_q;
  assign bus.rgb      = rgb_q;

endmodule

// File: tb/tb_word_renderer.sv
// Scoreboard bench for word_renderer: the stimulus side pushes the expected
// pixel_on/rgb/choose for every pixel-enable edge, a monitor pops and compares.
// Honours BLINK_EN when the design is built with it.
module tb_word_renderer;
  import word_pkg::*;

  typedef struct {
    logic       pon;
    logic [11:0] rgb;
    logic [5:0] choose;
    int         h;
    int         v;
  } exp_t;

  logic clk;
  logic rst;
  word_renderer_if bus ();

  exp_t sb[$];
  int   n_checks;
  int   n_pass;

  logic [5:0] m_choose;
  logic [5:0] m_row;
  bit         m_live;
  logic [4:0] m_blink;

  word_renderer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Glyph ROM model: row 0 has only its end bits set, other rows a fixed pattern.
  function automatic logic [679:0] rom_row(input logic [5:0] r);
    logic [679:0] w;
    w = '0;
    if (r == 6'd0) begin
      w[679] = 1'b1;
      w[0]   = 1'b1;
    end else begin
      for (int i = 0; i < 680; i++) begin
        w[i] = (((i + int'(r) * 13) % 7) == 0) || (((i ^ int'(r)) % 13) == 3);
      end
    end
    return w;
  endfunction

  assign bus.word = rom_row(bus.choose);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare the DUT outputs against one expected entry.
  task automatic checkOutput(input exp_t e, input string name);
    n_checks++;
    if (bus.pixel_on !== e.pon || bus.rgb !== e.rgb || bus.choose !== e.choose) begin
      $display("[TB] FAIL %s v=%0d h=%0d got pixel_on=%0b rgb=%03h choose=%0d, want pixel_on=%0b rgb=%03h choose=%0d",
               name, e.v, e.h, bus.pixel_on, bus.rgb, bus.choose, e.pon, e.rgb, e.choose);
    end else begin
      n_pass++;
    end
  endtask

  // Drive one pixel for ce_div clocks and queue the output expected after its enable edge.
  task automatic applyStimulus(input int h, input int v, input bit vs, input int ce_div);
    exp_t         e;
    logic [679:0] row;
    bus.hcnt      = 11'(h);
    bus.vcnt      = 11'(v);
    bus.vsync_pls = vs;
    bus.pix_ce    = 1'b1;
    e.h   = h;
    e.v   = v;
    e.pon = 1'b0;
    if (rst) begin
      m_choose = '0;
      m_live   = 1'b0;
      m_blink  = '0;
    end else begin
      if (vs) m_blink = m_blink + 5'd1;
      if (h == 198 && v >= 100 && v < 140) begin
        m_choose = 6'(v - 100);
        m_row    = m_choose;
        m_live   = 1'b1;
      end
      if (m_live && h >= 200 && h <= 879) begin
        row   = rom_row(m_row);
        e.pon = row[679 - (h - 200)];
      end
      if (h >= 879) m_live = 1'b0;
`ifdef BLINK_EN
      if (m_blink[4]) e.pon = 1'b0;
`endif
    end
    e.rgb    = e.pon ? 12'hFF0 : 12'h000;
    e.choose = m_choose;
    sb.push_back(e);
    repeat (ce_div) begin
      @(negedge clk);
      bus.pix_ce    = 1'b0;
      bus.vsync_pls = 1'b0;
    end
  endtask

  // Sweep one raster line, optionally pulsing reset at a chosen column.
  task automatic run_line(input int v, input int ce_div, input int rst_at, input bit vs);
    exp_t z;
    for (int h = 0; h <= 1000; h++) begin
      if (h == rst_at) begin
        rst = 1'b1;
        #1;
        m_choose = '0;
        m_live   = 1'b0;
        m_blink  = '0;
        z.pon = 1'b0; z.rgb = 12'h000; z.choose = 6'd0; z.h = h; z.v = v;
        checkOutput(z, "rst_async");
      end
      applyStimulus(h, v, vs && (h == 0), ce_div);
      if (h == rst_at) rst = 1'b0;
    end
  endtask

  // Monitor: every enabled edge presents a new output; pop and compare it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (bus.pix_ce === 1'b1) begin
        #1;
        if (sb.size() == 0) begin
          n_checks++;
          $display("[TB] FAIL sb_underflow got pixel_on=%0b choose=%0d, want a queued entry",
                   bus.pixel_on, bus.choose);
        end else begin
          e = sb.pop_front();
          checkOutput(e, "pixel");
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int guard;
    n_checks = 0;
    n_pass   = 0;
    m_choose = '0;
    m_row    = '0;
    m_live   = 1'b0;
    m_blink  = '0;
    rst           = 1'b1;
    bus.pix_ce    = 1'b0;
    bus.hcnt      = '0;
    bus.vcnt      = '0;
    bus.vsync_pls = 1'b0;
    @(negedge clk);

    $display("[TB] reset held with random raster");
    applyStimulus(198, 105, 1'b0, 1);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(int'($urandom_range(0, 1000)), int'($urandom_range(90, 150)), 1'b0, 1);
    end
    rst = 1'b0;

    $display("[TB] row 0 edge bits");
    run_line(100, 1, -1, 1'b0);
    $display("[TB] row 15 pattern");
    run_line(115, 1, -1, 1'b0);
    $display("[TB] lines outside banner");
    run_line(99, 1, -1, 1'b0);
    run_line(140, 1, -1, 1'b0);
    $display("[TB] slow pixel enable with mid-line reset");
    run_line(110, 4, 500, 1'b0);
    run_line(111, 4, -1, 1'b0);

`ifdef BLINK_EN
    $display("[TB] blink cycle");
    for (int f = 0; f < 34; f++) begin
      run_line(100, 1, -1, 1'b1);
    end
`endif

    guard = 0;
    while (sb.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    n_checks++;
    if (sb.size() != 0) begin
      $display("[TB] FAIL sb_drain got %0d entries left, want 0", sb.size());
    end else begin
      n_pass++;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
